slow_memory: RTL and testbench

SLOW_MEMORY -- requirements
Module: slow_memory

---
 rtl/slow_memory_pkg.sv | 16 +
 rtl/slow_memory.sv | 122 ++++++++++++
 tb/tb_slow_memory.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/slow_memory_pkg.sv
// Shared types and defaults for the slow_memory line-store model.
package slow_memory_pkg;

   localparam int unsigned LINE_W      = 128;
   localparam int unsigned ADDR_W      = 28;
   localparam int unsigned DEF_LATENCY = 8;
   localparam int unsigned DEF_DEPTH   = 256;
   localparam int unsigned CNT_W       = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/slow_memory.sv
// Fixed-latency 128-bit line memory: a request is accepted in IDLE, counted
// down in WAIT, and completed with a single mem_ready pulse in DONE.
module slow_memory
   import slow_memory_pkg::*;
#(
   parameter int unsigned LATENCY = DEF_LATENCY,
   parameter int unsigned DEPTH   = DEF_DEPTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [ADDR_W+3:4]   mem_addr,
   input  logic [LINE_W-1:0]   mem_wdata,
   output logic [LINE_W-1:0]   mem_rdata,
   output logic                mem_ready
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   // Line storage; left unreset so preloaded contents survive rst_n.
   logic [LINE_W-1:0] mem [0:DEPTH-1];

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              ready_q;
   logic [LINE_W-1:0] rdata_q;

   logic              req;
   logic              enter_done;

   // Upper line-address bits are ignored so the index wraps.
   if (IDX_W < ADDR_W) begin : g_addr_hi
      logic addr_hi_unused;
      assign addr_hi_unused = ^mem_addr[ADDR_W+3:IDX_W+4];
   end

   // Next-state, counter and operand selection. In IDLE the live inputs are
   // selected so that LATENCY=1 can complete on the accepting edge itself.
   always_comb begin
      req        = mem_read | mem_write;
      enter_done = 1'b0;
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_wr_d    = op_wr_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               op_wr_d = mem_write;
               idx_d   = mem_addr[IDX_W+3:4];
               wdata_d = mem_wdata;
               if (LATENCY == 1) begin
                  state_d    = DONE;
                  cnt_d      = '0;
                  enter_done = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d    = DONE;
               cnt_d      = '0;
               enter_done = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM, latched operands and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         ready_q <= enter_done;
         if (enter_done && !op_wr_d) begin
            rdata_q <= mem[idx_d];
         end
      end
   end

   // Line write on entry to DONE; gated by rst_n so an in-flight write is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && enter_done && op_wr_d) begin
         mem[idx_d] <= wdata_d;
      end
   end

   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_slow_memory.sv
// Scoreboard bench for slow_memory at default LATENCY=8, DEPTH=256.
module tb_slow_memory;

   localparam int unsigned LAT = 8;

   logic          clk;
   logic          rst_n;
   logic          mem_read;
   logic          mem_write;
   logic [31:4]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata;
   logic          mem_ready;

   int unsigned   tests_run    = 0;
   int unsigned   tests_failed = 0;
   int unsigned   pulses       = 0;
   int unsigned   exp_pulses   = 0;

   logic [127:0]  ref_mem [256];
   logic [127:0]  last_rd;
   logic [127:0]  exp_q [$];

   slow_memory #(.LATENCY(LAT), .DEPTH(256)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Every ready pulse must match the oldest outstanding expectation.
   always @(posedge clk) begin
      #1;
      if (mem_ready === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            check("spurious_ready", 128'd1, 128'd0);
         end else begin
            check("rdata", mem_rdata, exp_q.pop_front());
         end
      end
   end

   task automatic issue(input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] data, input bit hold_extra);
      int unsigned idx;
      int unsigned n;
      bit          seen;
      idx = 32'(addr[7:0]);
      @(negedge clk);
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = addr;
      mem_wdata = data;
      if (wr) ref_mem[idx] = data;
      else    last_rd = ref_mem[idx];
      exp_q.push_back(last_rd);
      exp_pulses++;
      @(posedge clk);
      n    = 1;
      seen = 1'b0;
      @(negedge clk);
      mem_addr  = ~addr;
      mem_wdata = ~data;
      while (!seen && n < 40) begin
         @(posedge clk);
         n++;
         #1;
         if (mem_ready === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         check("ready_timeout", 128'd0, 128'd1);
      end else begin
         check("latency", 128'(n), 128'(LAT));
      end
      if (hold_extra) begin
         @(posedge clk); #1;
         check("ready_width", 128'(mem_ready), 128'd0);
         @(negedge clk);
         mem_read = 1'b0; mem_write = 1'b0;
         @(posedge clk); #1;
         check("held_req_ignored", 128'(mem_ready), 128'd0);
      end else begin
         @(negedge clk);
         mem_read = 1'b0; mem_write = 1'b0;
         @(posedge clk); #1;
         check("ready_width", 128'(mem_ready), 128'd0);
      end
   endtask

   initial begin
      logic [127:0] a5;
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      mem_addr = '0; mem_wdata = '0; last_rd = '0;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = {4{32'(i) ^ 32'hC0DE_0000}};
         dut.mem[i] = ref_mem[i];
      end
      ref_mem[5] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      dut.mem[5] = ref_mem[5];
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 128'(mem_ready), 128'd0);
      check("reset_rdata", mem_rdata, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Preloaded read, request held through the recovery edge.
      issue(1'b1, 1'b0, 28'h5, 128'h0, 1'b1);
      // Write A5 pattern then read it back.
      a5 = {16{8'hA5}};
      issue(1'b0, 1'b1, 28'h3, a5, 1'b0);
      issue(1'b1, 1'b0, 28'h3, 128'h0, 1'b0);
      // Address wrap.
      issue(1'b1, 1'b0, 28'h105, 128'h0, 1'b0);
      // Read and write together: write only.
      issue(1'b1, 1'b1, 28'h7, 128'h1, 1'b0);
      check("rw_mem7", dut.mem[7], 128'h1);

      // Write dropped mid-WAIT: no pulse, no update.
      @(negedge clk);
      mem_write = 1'b1; mem_addr = 28'h9; mem_wdata = {4{32'hDEAD_BEEF}};
      repeat (3) @(posedge clk);
      @(negedge clk);
      mem_write = 1'b0;
      repeat (LAT + 4) @(posedge clk);
      #1;
      check("abort_mem9", dut.mem[9], ref_mem[9]);

      // Reset asserted mid-WAIT after a read has set rdata.
      issue(1'b1, 1'b0, 28'h5, 128'h0, 1'b0);
      @(negedge clk);
      mem_write = 1'b1; mem_addr = 28'hB; mem_wdata = {4{32'h1234_5678}};
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_ready", 128'(mem_ready), 128'd0);
      check("rst_rdata", mem_rdata, 128'd0);
      mem_write = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_rd = '0;
      check("rst_mem11", dut.mem[11], ref_mem[11]);
      check("rst_mem3", dut.mem[3], a5);
      issue(1'b1, 1'b0, 28'h3, 128'h0, 1'b0);

      // Random write/read pairs.
      for (int k = 0; k < 4; k++) begin
         logic [27:0]  ra;
         logic [127:0] rd;
         ra = 28'($urandom);
         rd = {$urandom, $urandom, $urandom, $urandom};
         issue(1'b0, 1'b1, ra, rd, 1'b0);
         issue(1'b1, 1'b0, ra ^ 28'h0A00, 128'h0, 1'b0);
      end

      repeat (LAT + 4) @(posedge clk);
      #2;
      check("pulse_count", 128'(pulses), 128'(exp_pulses));
      check("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
